mandelbrot_scan: RTL and testbench

- Upstream sequencer for the mandelbrot iteration unit. Walks a WIDTH x HEIGHT pixel grid in raster order and generates Q6.10 complex coordinates for each pixel.
- Issues one start pulse per pixel and waits for the unit's busy to rise and fall. Then presents the 4-bit iteration count on a valid/ready pixel stream toward the frame buffer / display writer.

---
 rtl/mandelbrot_scan.sv | 157 +++++++++++++++
 tb/tb_mandelbrot_scan.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_scan.sv
// Raster-order pixel sequencer for the mandelbrot iteration unit.
// Latency: ISSUE 1 + WAIT_HI 1 + unit run time + EMIT (>=1) cycles per pixel.
// Backpressure: holds the pixel while pix_ready_i is low; no new start until accepted.
//
// Ports:
//   raw_clk_i, reset_i        clock, synchronous active-high reset
//   go_i                      start a frame (sampled in IDLE only)
//   r/i_start_i, r/i_step_i   Q6.10 frame origin and per-column/per-row steps
//   mb_start_o, mb_r_o, mb_i_o, mb_result_i, mb_busy_i   iteration unit handshake
//   pix_valid_o/pix_ready_i, pix_x_o, pix_y_o, pix_data_o pixel stream
//   busy_o, done_o            frame in progress, end-of-frame pulse
module mandelbrot_scan #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int X_BITS = 7,
  parameter int Y_BITS = 6
) (
  input  logic              raw_clk_i,
  input  logic              reset_i,
  input  logic              go_i,
  input  logic [15:0]       r_start_i,
  input  logic [15:0]       i_start_i,
  input  logic [15:0]       r_step_i,
  input  logic [15:0]       i_step_i,
  output logic              mb_start_o,
  output logic [15:0]       mb_r_o,
  output logic [15:0]       mb_i_o,
  input  logic [3:0]        mb_result_i,
  input  logic              mb_busy_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [X_BITS-1:0] pix_x_o,
  output logic [Y_BITS-1:0] pix_y_o,
  output logic [3:0]        pix_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_EMIT
  } state_t;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

  state_t            state_q, state_d;
  logic [15:0]       r_start_q, r_start_d;
  logic [15:0]       r_step_q, r_step_d;
  logic [15:0]       i_step_q, i_step_d;
  logic [15:0]       cur_r_q, cur_r_d;
  logic [15:0]       cur_i_q, cur_i_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [3:0]        data_q, data_d;
  logic              done_q, done_d;

  always_ff @(posedge raw_clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      r_start_q <= '0;
      r_step_q  <= '0;
      i_step_q  <= '0;
      cur_r_q   <= '0;
      cur_i_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_start_q <= r_start_d;
      r_step_q  <= r_step_d;
      i_step_q  <= i_step_d;
      cur_r_q   <= cur_r_d;
      cur_i_q   <= cur_i_d;
      x_q       <= x_d;
      y_q       <= y_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_start_d   = r_start_q;
    r_step_d    = r_step_q;
    i_step_d    = i_step_q;
    cur_r_d     = cur_r_q;
    cur_i_d     = cur_i_q;
    x_d         = x_q;
    y_d         = y_q;
    data_d      = data_q;
    done_d      = 1'b0;
    mb_start_o  = 1'b0;
    pix_valid_o = 1'b0;
    busy_o      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // done_q marks the end-of-frame cycle; a go seen then is dropped.
        if (go_i && !done_q) begin
          r_start_d = r_start_i;
          r_step_d  = r_step_i;
          i_step_d  = i_step_i;
          cur_r_d   = r_start_i;
          cur_i_d   = i_start_i;
          x_d       = '0;
          y_d       = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mb_start_o = 1'b1;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (mb_busy_i) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!mb_busy_i) begin
          data_d  = mb_result_i;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        pix_valid_o = 1'b1;
        if (pix_ready_i) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + X_BITS'(1);
            cur_r_d = cur_r_q + r_step_q;   // wraps modulo 2^16
            state_d = S_ISSUE;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + Y_BITS'(1);
            cur_r_d = r_start_q;
            cur_i_d = cur_i_q + i_step_q;
            state_d = S_ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Coordinates only move on a pixel accept, so they are stable for the
  // whole time the iteration unit is re-reading them.
  assign mb_r_o     = cur_r_q;
  assign mb_i_o     = cur_i_q;
  assign pix_x_o    = x_q;
  assign pix_y_o    = y_q;
  assign pix_data_o = data_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_mandelbrot_scan.sv
// Bench for mandelbrot_scan: two instances (2x1 and 3x2 grids) share one
// iteration-unit stub selected by sel. The 2x1 stub mode returns 0 when
// |c|^2 >= 4 and 15 otherwise; the 3x2 mode returns x+y of its own raster count.
module tb_mandelbrot_scan;

  logic        raw_clk = 1'b0;
  logic        reset, go, sel, pix_ready, stub_clr;
  logic [15:0] r_start, i_start, r_step, i_step;

  logic        a_start, a_valid, a_busy, a_done;
  logic [15:0] a_r, a_i;
  logic [6:0]  a_x;
  logic [5:0]  a_y;
  logic [3:0]  a_data;
  logic        b_start, b_valid, b_busy, b_done;
  logic [15:0] b_r, b_i;
  logic [6:0]  b_x;
  logic [5:0]  b_y;
  logic [3:0]  b_data;

  logic        go_a, go_b;
  logic        mb_start, pix_valid, busy, done;
  logic [15:0] mb_r, mb_i;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic [3:0]  pix_data;

  logic        stub_busy = 1'b0;
  logic [3:0]  stub_result = 4'd0;
  int          stub_cnt = 0;
  int          sx = 0, sy = 0;

  int errors = 0;
  int checks = 0;

  always #5 raw_clk = ~raw_clk;

  assign go_a      = go & ~sel;
  assign go_b      = go & sel;
  assign mb_start  = sel ? b_start  : a_start;
  assign mb_r      = sel ? b_r      : a_r;
  assign mb_i      = sel ? b_i      : a_i;
  assign pix_valid = sel ? b_valid  : a_valid;
  assign pix_x     = sel ? b_x      : a_x;
  assign pix_y     = sel ? b_y      : a_y;
  assign pix_data  = sel ? b_data   : a_data;
  assign busy      = sel ? b_busy   : a_busy;
  assign done      = sel ? b_done   : a_done;

  mandelbrot_scan #(.WIDTH(2), .HEIGHT(1), .X_BITS(7), .Y_BITS(6)) u_a (
    .raw_clk_i(raw_clk), .reset_i(reset), .go_i(go_a),
    .r_start_i(r_start), .i_start_i(i_start), .r_step_i(r_step), .i_step_i(i_step),
    .mb_start_o(a_start), .mb_r_o(a_r), .mb_i_o(a_i),
    .mb_result_i(stub_result), .mb_busy_i(stub_busy),
    .pix_valid_o(a_valid), .pix_ready_i(pix_ready),
    .pix_x_o(a_x), .pix_y_o(a_y), .pix_data_o(a_data),
    .busy_o(a_busy), .done_o(a_done));

  mandelbrot_scan #(.WIDTH(3), .HEIGHT(2), .X_BITS(7), .Y_BITS(6)) u_b (
    .raw_clk_i(raw_clk), .reset_i(reset), .go_i(go_b),
    .r_start_i(r_start), .i_start_i(i_start), .r_step_i(r_step), .i_step_i(i_step),
    .mb_start_o(b_start), .mb_r_o(b_r), .mb_i_o(b_i),
    .mb_result_i(stub_result), .mb_busy_i(stub_busy),
    .pix_valid_o(b_valid), .pix_ready_i(pix_ready),
    .pix_x_o(b_x), .pix_y_o(b_y), .pix_data_o(b_data),
    .busy_o(b_busy), .done_o(b_done));

  // 0 if |c|^2 >= 4.0 (4.0 is 4<<20 in the Q12.20 square), else 15.
  function automatic logic [3:0] esc(input logic [15:0] r, input logic [15:0] i);
    longint rr, ii;
    rr = longint'($signed(r));
    ii = longint'($signed(i));
    return ((rr * rr + ii * ii) >= longint'(4194304)) ? 4'd0 : 4'd15;
  endfunction

  // Stub: busy rises the cycle after start is sampled and stays high 2 cycles.
  // It is not reset with the DUT: it finishes its pixel on its own.
  always @(posedge raw_clk) begin
    if (stub_clr) begin
      sx <= 0;
      sy <= 0;
    end else if (mb_start) begin
      stub_busy   <= 1'b1;
      stub_cnt    <= 2;
      stub_result <= sel ? 4'(sx + sy) : esc(mb_r, mb_i);
      if (sx == 2) begin
        sx <= 0;
        sy <= sy + 1;
      end else begin
        sx <= sx + 1;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 1) stub_busy <= 1'b0;
      stub_cnt <= stub_cnt - 1;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic             sel;      // 0: 2x1 grid, 1: 3x2 grid
    logic [15:0]      rs, is, rst, ist;
    int               stall;    // cycles of pix_ready low per pixel
    int               poke;     // 1: go mid-frame, 2: go on done cycle
    int               npix;
    logic [0:5][15:0] er;       // expected mb_r per pixel, pixel 0 first
    logic [0:5][15:0] ei;
    logic [0:5][3:0]  ed;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input int v);
    vec_t        t;
    logic [15:0] got_r [0:5];
    logic [15:0] got_i [0:5];
    logic [6:0]  got_x [0:5];
    logic [5:0]  got_y [0:5];
    logic [3:0]  got_d [0:5];
    logic [6:0]  hx;
    logic [5:0]  hy;
    logic [3:0]  hd;
    int nr = 0, np = 0, ndone = 0, wait_cnt = 0, post_cnt = 0, cyc = 0, w;
    t = vecs[v];
    w = t.sel ? 3 : 2;
    hx = '0; hy = '0; hd = '0;
    @(negedge raw_clk);
    sel = t.sel; r_start = t.rs; i_start = t.is; r_step = t.rst; i_step = t.ist;
    pix_ready = (t.stall == 0);
    stub_clr = 1'b1;
    @(negedge raw_clk);
    stub_clr = 1'b0;
    go = 1'b1;
    @(negedge raw_clk);
    go = 1'b0;
    for (cyc = 0; cyc < 400 && post_cnt < 4; cyc++) begin
      if (t.poke == 1 && cyc == 8) begin
        go = 1'b1; r_start = 16'h1234; r_step = 16'h0001;
      end else if (t.poke == 1 && cyc == 9) begin
        go = 1'b0; r_start = t.rs; r_step = t.rst;
      end
      if (mb_start) begin
        if (nr < 6) begin got_r[nr] = mb_r; got_i[nr] = mb_i; end
        nr++;
        check("start_while_busy_or_valid", 64'({stub_busy, pix_valid}), 64'(0));
      end
      if (pix_valid) begin
        if (wait_cnt > 0)
          check("stall_stable", 64'({pix_x, pix_y, pix_data}), 64'({hx, hy, hd}));
        else begin
          hx = pix_x; hy = pix_y; hd = pix_data;
        end
        if (wait_cnt < t.stall) begin
          pix_ready = 1'b0;
          wait_cnt++;
        end else begin
          pix_ready = 1'b1;
          if (np < 6) begin got_x[np] = hx; got_y[np] = hy; got_d[np] = hd; end
          np++;
          wait_cnt = 0;
        end
      end else begin
        pix_ready = (t.stall == 0);
      end
      if (post_cnt > 0) post_cnt++;
      if (done) begin
        ndone++;
        check("busy_on_done", 64'(busy), 64'(0));
        if (t.poke == 2) go = 1'b1;
        if (post_cnt == 0) post_cnt = 1;
      end
      if (t.poke == 2 && post_cnt == 2) begin
        check("go_on_done_ignored", 64'({busy, mb_start}), 64'(0));
        go = 1'b0;
      end
      @(negedge raw_clk);
    end
    go = 1'b0;
    if (post_cnt < 4) begin
      errors++;
      $display("FAIL frame%0d_timeout: no done within cycle budget", v);
    end
    check("pixel_count", 64'(np), 64'(t.npix));
    check("start_count", 64'(nr), 64'(t.npix));
    check("done_pulses", 64'(ndone), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
    for (int k = 0; k < t.npix && k < np && k < nr; k++) begin
      check($sformatf("f%0d_pix%0d_xyd", v, k), 64'({got_x[k], got_y[k], got_d[k]}),
            64'({7'(k % w), 6'(k / w), t.ed[k]}));
      check($sformatf("f%0d_pix%0d_ri", v, k), 64'({got_r[k], got_i[k]}),
            64'({t.er[k], t.ei[k]}));
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; sel = 1'b0; pix_ready = 1'b1; stub_clr = 1'b0;
    r_start = '0; i_start = '0; r_step = '0; i_step = '0;

    // 2x1: c=0 never escapes (15), c=2.0 escapes at once (0).
    vecs[0] = '{sel:1'b0, rs:16'h0000, is:16'h0000, rst:16'h0800, ist:16'h0000,
                stall:0, poke:0, npix:2,
                er:{16'h0000, 16'h0800, 64'h0}, ei:96'h0,
                ed:{4'd15, 4'd0, 16'h0}};
    // 3x2 grid with data = x+y; go on the done cycle must be dropped.
    vecs[1] = '{sel:1'b1, rs:16'hF800, is:16'hFC00, rst:16'h0040, ist:16'h0100,
                stall:0, poke:2, npix:6,
                er:{16'hF800, 16'hF840, 16'hF880, 16'hF800, 16'hF840, 16'hF880},
                ei:{16'hFC00, 16'hFC00, 16'hFC00, 16'hFD00, 16'hFD00, 16'hFD00},
                ed:{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3}};
    vecs[2] = vecs[1];
    vecs[2].stall = 5;
    vecs[2].poke  = 0;
    // Real coordinate wraps from 0x7FC0 to 0x8000.
    vecs[3] = '{sel:1'b0, rs:16'h7FC0, is:16'h0100, rst:16'h0040, ist:16'h0000,
                stall:0, poke:0, npix:2,
                er:{16'h7FC0, 16'h8000, 64'h0}, ei:{16'h0100, 16'h0100, 64'h0},
                ed:24'h0};
    vecs[4] = vecs[1];
    vecs[4].poke = 1;

    repeat (3) @(negedge raw_clk);
    check("reset_a", 64'({a_start, a_r, a_i, a_valid, a_x, a_y, a_data, a_busy, a_done}), 64'(0));
    check("reset_b", 64'({b_start, b_r, b_i, b_valid, b_x, b_y, b_data, b_busy, b_done}), 64'(0));
    reset = 1'b0;

    for (int v = 0; v < 5; v++) run_frame(v);

    // Reset while in WAIT_LO.
    @(negedge raw_clk);
    sel = 1'b1; r_start = 16'hF800; i_start = 16'hFC00; r_step = 16'h0040; i_step = 16'h0100;
    pix_ready = 1'b1; stub_clr = 1'b1;
    @(negedge raw_clk);
    stub_clr = 1'b0; go = 1'b1;
    @(negedge raw_clk);
    go = 1'b0;
    check("rst_seq_issue", 64'(mb_start), 64'(1));
    @(negedge raw_clk);
    @(negedge raw_clk);
    check("rst_seq_in_wait_lo", 64'({stub_busy, busy, mb_start, pix_valid}), 64'(4'b1100));
    reset = 1'b1;
    @(negedge raw_clk);
    check("rst_mid_frame_outputs",
          64'({b_start, b_r, b_i, b_valid, b_x, b_y, b_data, b_busy, b_done}), 64'(0));
    reset = 1'b0;
    for (int c = 0; c < 50 && stub_busy; c++) @(negedge raw_clk);
    check("stub_idle_after_reset", 64'(stub_busy), 64'(0));
    run_frame(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
